dmem_bridge: RTL and testbench
==============================

DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 The module SHALL have parameter WAIT_CYCLES, default 2, giving the wait states (0..15) inserted before each SRAM strobe.
REQ-002 The module SHALL have parameter ADDR_W, default 14, giving the SRAM word-address width.
REQ-003 CLK  input  1  sole clock; all state changes on its rising edge.
REQ-004 RST  input  1  asynchronous, active-low reset.
REQ-005 DataMemAddress  input  32  byte address from core; bits [1:0] ignored.
REQ-006 WriteData  input  32  store data from core.
REQ-007 DataMemReadEnable  input  1  load request, held high until acknowledged.
REQ-008 DataMemWriteEnable  input  1  store request, held high until acknowledged.
REQ-009 DataMemByteEnable  input  4  per-byte store lanes.
REQ-010 DataMemAck  output  1  one-cycle completion pulse to core.
REQ-011 ReadDataOriginal  output  32  load data to core.
REQ-012 SramCE, SramWE  output  1 each  synchronous SRAM chip-enable and write strobe.
REQ-013 SramAddr  output  ADDR_W  word address.
REQ-014 SramBE  output  4  byte lanes.
REQ-015 SramWData  output  32  write data.
REQ-016 SramRData  input  32  read data, valid the cycle after SramCE.
REQ-017 RangeErr  output  1  sticky out-of-range flag (see Configuration).

Function
REQ-018 FSM states SHALL be IDLE, WAIT, ACCESS and RESP.
REQ-019 IDLE: if WE or RE is high, latch address, data, BE and op; go to WAIT when WAIT_CYCLES>0, else to ACCESS.
REQ-020 If WE and RE are both high, the access SHALL be a write and the read SHALL be dropped.
REQ-021 WAIT: a down-counter SHALL load WAIT_CYCLES on entry and decrement each cycle; the FSM SHALL move to ACCESS after exactly WAIT_CYCLES cycles in WAIT.
REQ-022 ACCESS: assert SramCE=1 for exactly one cycle, with:
- SramWE=op write;
- SramAddr=latched address[ADDR_W+1:2];
- SramWData=latched data;
- SramBE=latched BE for writes, 4'hF for reads.
Then go to RESP.
REQ-023 RESP: assert DataMemAck=1 for exactly one cycle, then return to IDLE.
REQ-024 On a read, ReadDataOriginal SHALL equal SramRData during RESP; a holding register SHALL capture it at the end of RESP, and ReadDataOriginal SHALL show that register at all other times.
REQ-025 A write SHALL NOT alter ReadDataOriginal.
REQ-026 Latency: with the request first high in IDLE cycle 0, SramCE SHALL be high in cycle WAIT_CYCLES+1 and DataMemAck in cycle WAIT_CYCLES+2.
REQ-027 Once latched, an access SHALL complete even if the core enables fall mid-access; enables SHALL be ignored outside IDLE.
REQ-028 An enable still high in the IDLE cycle after RESP SHALL start a new access (back-to-back permitted).
REQ-029 Outside ACCESS, SramCE and SramWE SHALL be 0. Outside RESP, DataMemAck SHALL be 0.

Reset
REQ-030 While RST=0, the block SHALL:
- force IDLE and clear the counter and holding register;
- hold DataMemAck, SramCE, SramWE and RangeErr at 0;
- hold ReadDataOriginal, SramAddr, SramBE and SramWData at 0.
REQ-031 Reset asserted mid-access SHALL abort the access with no SRAM strobe or ack afterwards; the first request after release SHALL be sampled in IDLE.

Configuration
REQ-032 With DMEM_BRIDGE_RANGE_CHECK_EN defined, an access with DataMemAddress[31:ADDR_W+2] nonzero SHALL:
- follow normal FSM timing;
- suppress SramCE in ACCESS;
- return 32'h0 on a read;
- still pulse DataMemAck;
- set RangeErr=1 until reset.
REQ-033 Without DMEM_BRIDGE_RANGE_CHECK_EN, the upper address bits SHALL be ignored (aliasing) and RangeErr SHALL be tied to 0.

Verification
REQ-034 Read, WAIT_CYCLES=2: preload word 0x10 = 32'hCAFE_F00D; RE high with address 32'h40 at cycle 0 -> SramCE=1 and SramAddr=0x10 at cycle 3; DataMemAck=1 and ReadDataOriginal=32'hCAFE_F00D at cycle 4.
REQ-035 Write, WAIT_CYCLES=0: WE with address 32'h8, data 32'h1234_5678, BE=4'b0011 -> SramCE=SramWE=1, SramBE=4'b0011, SramAddr=2 at cycle 1; ack at cycle 2; ReadDataOriginal unchanged.
REQ-036 RE and WE both high at cycle 0 -> exactly one SRAM strobe with SramWE=1 and exactly one ack.
REQ-037 RE held high through ack -> second access starts in the IDLE cycle after RESP; acks spaced WAIT_CYCLES+3 cycles apart.
REQ-038 RST pulled low during WAIT -> no SramCE and no ack; all outputs 0; a later read completes with normal latency.
REQ-039 With DMEM_BRIDGE_RANGE_CHECK_EN and ADDR_W=14: read address 32'h0001_0000 -> no SramCE, ack at cycle WAIT_CYCLES+2, data 0, RangeErr=1 and held until reset.

Source files
------------

// File: rtl/dmem_bridge_if.sv
// Core-side data-memory port plus synchronous SRAM port of the dmem bridge.
// slave = the bridge, master = the core and SRAM around it.
interface dmem_bridge_if #(
  parameter int ADDR_W = 14
);
  logic [31:0]       DataMemAddress;
  logic [31:0]       WriteData;
  logic              DataMemReadEnable;
  logic              DataMemWriteEnable;
  logic [3:0]        DataMemByteEnable;
  logic              DataMemAck;
  logic [31:0]       ReadDataOriginal;
  logic              SramCE;
  logic              SramWE;
  logic [ADDR_W-1:0] SramAddr;
  logic [3:0]        SramBE;
  logic [31:0]       SramWData;
  logic [31:0]       SramRData;
  logic              RangeErr;

  modport slave (
    input  DataMemAddress, WriteData, DataMemReadEnable, DataMemWriteEnable,
           DataMemByteEnable, SramRData,
    output DataMemAck, ReadDataOriginal, SramCE, SramWE, SramAddr, SramBE,
           SramWData, RangeErr
  );

  modport master (
    output DataMemAddress, WriteData, DataMemReadEnable, DataMemWriteEnable,
           DataMemByteEnable, SramRData,
    input  DataMemAck, ReadDataOriginal, SramCE, SramWE, SramAddr, SramBE,
           SramWData, RangeErr
  );
endinterface

// File: rtl/dmem_bridge.sv
// Core load/store port to synchronous SRAM bridge with programmable wait states.
// Optional out-of-range detection: define DMEM_BRIDGE_RANGE_CHECK_EN.
module dmem_bridge #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 14
) (
  input  logic        CLK,
  input  logic        RST,
  dmem_bridge_if.slave bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WAIT   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic              wr_q;
  logic              oor_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [3:0]        be_q;
  logic [31:0]       hold_q;
  logic              req;
  logic              req_oor;
  logic [31:0]       rd_mux;

  assign req = bus.DataMemReadEnable | bus.DataMemWriteEnable;

`ifdef DMEM_BRIDGE_RANGE_CHECK_EN
  assign req_oor = |bus.DataMemAddress[31:ADDR_W+2];
`else
  assign req_oor = 1'b0;
`endif

  // Out-of-range loads return zero rather than whatever the SRAM bus holds.
  assign rd_mux = oor_q ? 32'h0 : bus.SramRData;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      wr_q   <= 1'b0;
      oor_q  <= 1'b0;
      addr_q <= '0;
      data_q <= 32'h0;
      be_q   <= 4'h0;
      hold_q <= 32'h0;
    end else begin
      case (state)
        IDLE: if (req) begin
          addr_q <= bus.DataMemAddress[ADDR_W+1:2];
          data_q <= bus.WriteData;
          be_q   <= bus.DataMemByteEnable;
          wr_q   <= bus.DataMemWriteEnable;  // write wins when both are high
          oor_q  <= req_oor;
          cnt    <= 4'(WAIT_CYCLES);
          state  <= (WAIT_CYCLES > 0) ? WAIT : ACCESS;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt <= 4'd1) state <= ACCESS;
        end
        ACCESS: state <= RESP;
        RESP: begin
          if (!wr_q) hold_q <= rd_mux;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DMEM_BRIDGE_RANGE_CHECK_EN
  logic range_err;
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) range_err <= 1'b0;
    else if (state == IDLE && req && req_oor) range_err <= 1'b1;
  end
  assign bus.RangeErr = range_err;
`else
  assign bus.RangeErr = 1'b0;
`endif

  assign bus.SramCE           = (state == ACCESS) && !oor_q;
  assign bus.SramWE           = (state == ACCESS) && !oor_q && wr_q;
  assign bus.SramAddr         = addr_q;
  assign bus.SramWData        = data_q;
  assign bus.SramBE           = (state == ACCESS && !wr_q) ? 4'hF : be_q;
  assign bus.DataMemAck       = (state == RESP);
  assign bus.ReadDataOriginal = (state == RESP && !wr_q) ? rd_mux : hold_q;
endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench: two bridges (WAIT_CYCLES=2 and 0) each against a small SRAM model.
module tb_dmem_bridge;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  dmem_bridge_if #(.ADDR_W(14)) b2 ();
  dmem_bridge_if #(.ADDR_W(14)) b0 ();

  dmem_bridge #(.WAIT_CYCLES(2), .ADDR_W(14)) u_d2 (.CLK(CLK), .RST(RST), .bus(b2));
  dmem_bridge #(.WAIT_CYCLES(0), .ADDR_W(14)) u_d0 (.CLK(CLK), .RST(RST), .bus(b0));

  logic [31:0] mem2 [0:16383];
  logic [31:0] mem0 [0:16383];
  logic [31:0] rd2 = 32'h0;
  logic [31:0] rd0 = 32'h0;
  assign b2.SramRData = rd2;
  assign b0.SramRData = rd0;

  always @(posedge CLK) begin
    if (b2.SramCE) begin
      if (b2.SramWE) begin
        for (int i = 0; i < 4; i++)
          if (b2.SramBE[i]) mem2[b2.SramAddr][8*i +: 8] <= b2.SramWData[8*i +: 8];
      end else rd2 <= mem2[b2.SramAddr];
    end
    if (b0.SramCE) begin
      if (b0.SramWE) begin
        for (int i = 0; i < 4; i++)
          if (b0.SramBE[i]) mem0[b0.SramAddr][8*i +: 8] <= b0.SramWData[8*i +: 8];
      end else rd0 <= mem0[b0.SramAddr];
    end
  end

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Results of the last acc() call
  int          ce_c, ack_c, ce_n, ack_n;
  logic [31:0] sa, swd, rdat;
  logic        swe;
  logic [3:0]  sbe;

  task automatic drive(input bit sel, input logic wr, input logic rd,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    if (sel) begin
      b0.DataMemAddress = a; b0.WriteData = d; b0.DataMemByteEnable = be;
      b0.DataMemWriteEnable = wr; b0.DataMemReadEnable = rd;
    end else begin
      b2.DataMemAddress = a; b2.WriteData = d; b2.DataMemByteEnable = be;
      b2.DataMemWriteEnable = wr; b2.DataMemReadEnable = rd;
    end
  endtask

  // Called at a negedge (cycle 0); holds the enables until ack, like a core would.
  task automatic acc(input bit sel, input logic wr, input logic rd,
                     input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    logic ce, ack;
    ce_c = -1; ack_c = -1; ce_n = 0; ack_n = 0;
    sa = 'x; swd = 'x; rdat = 'x; swe = 1'bx; sbe = 'x;
    drive(sel, wr, rd, a, d, be);
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge CLK);
      ce  = sel ? b0.SramCE : b2.SramCE;
      ack = sel ? b0.DataMemAck : b2.DataMemAck;
      if (ce) begin
        ce_n++; ce_c = c;
        sa   = sel ? 32'(b0.SramAddr) : 32'(b2.SramAddr);
        swd  = sel ? b0.SramWData : b2.SramWData;
        swe  = sel ? b0.SramWE : b2.SramWE;
        sbe  = sel ? b0.SramBE : b2.SramBE;
      end
      if (ack) begin
        ack_n++; ack_c = c;
        rdat = sel ? b0.ReadDataOriginal : b2.ReadDataOriginal;
        break;
      end
    end
    drive(sel, 1'b0, 1'b0, a, d, be);
  endtask

  initial begin
    int a1, a2, n;
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    mem2[16] = 32'hCAFE_F00D;
    mem2[0]  = 32'h0BAD_0000;
    mem0[5]  = 32'hA5A5_0001;
    mem0[2]  = 32'hFFFF_FFFF;
    mem0[3]  = 32'h0;

    repeat (2) @(negedge CLK);
    chk("rst_ack",   32'(b2.DataMemAck), 0);
    chk("rst_ce",    32'(b2.SramCE), 0);
    chk("rst_we",    32'(b2.SramWE), 0);
    chk("rst_rerr",  32'(b2.RangeErr), 0);
    chk("rst_rdata", b2.ReadDataOriginal, 0);
    chk("rst_addr",  32'(b2.SramAddr), 0);
    chk("rst_be",    32'(b2.SramBE), 0);
    chk("rst_wdata", b2.SramWData, 0);
    RST = 1'b1;
    @(negedge CLK);

    // Read with two wait states
    acc(0, 0, 1, 32'h40, 0, 0);
    chk("rd_ce_cyc",  ce_c, 3);
    chk("rd_ce_n",    ce_n, 1);
    chk("rd_addr",    sa, 32'h10);
    chk("rd_we",      32'(swe), 0);
    chk("rd_be",      32'(sbe), 32'hF);
    chk("rd_ack_cyc", ack_c, 4);
    chk("rd_data",    rdat, 32'hCAFE_F00D);
    @(negedge CLK);
    chk("rd_ack_low", 32'(b2.DataMemAck), 0);
    chk("rd_hold",    b2.ReadDataOriginal, 32'hCAFE_F00D);

    // Zero wait states: read then a partial write that must not disturb read data
    acc(1, 0, 1, 32'h14, 0, 0);
    chk("rd0_ack_cyc", ack_c, 2);
    chk("rd0_data",    rdat, 32'hA5A5_0001);
    @(negedge CLK);
    acc(1, 1, 0, 32'h8, 32'h1234_5678, 4'b0011);
    chk("wr_ce_cyc",  ce_c, 1);
    chk("wr_we",      32'(swe), 1);
    chk("wr_be",      32'(sbe), 32'h3);
    chk("wr_addr",    sa, 32'h2);
    chk("wr_wdata",   swd, 32'h1234_5678);
    chk("wr_ack_cyc", ack_c, 2);
    chk("wr_rd_keep", rdat, 32'hA5A5_0001);
    @(negedge CLK);
    chk("wr_mem",      mem0[2], 32'hFFFF_5678);
    chk("wr_rd_after", b0.ReadDataOriginal, 32'hA5A5_0001);

    // RE and WE together: one write strobe, one ack, nothing after
    acc(1, 1, 1, 32'hC, 32'hDEAD_BEEF, 4'hF);
    chk("both_ce_n",  ce_n, 1);
    chk("both_we",    32'(swe), 1);
    chk("both_ack_n", ack_n, 1);
    n = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      if (b0.SramCE || b0.DataMemAck) n++;
    end
    chk("both_extra", n, 0);
    chk("both_mem",   mem0[3], 32'hDEAD_BEEF);

    // RE held through ack: back-to-back accesses
    a1 = -1; a2 = -1;
    drive(0, 0, 1, 32'h40, 0, 0);
    for (int c = 0; c < 16; c++) begin
      if (c > 0) @(negedge CLK);
      if (b2.DataMemAck) begin
        if (a1 < 0) a1 = c;
        else begin
          a2 = c;
          chk("b2b_data", b2.ReadDataOriginal, 32'hCAFE_F00D);
          break;
        end
      end
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("b2b_first",   a1, 4);
    chk("b2b_spacing", a2 - a1, 5);
    @(negedge CLK);

    // Reset during WAIT aborts the access
    drive(0, 0, 1, 32'h40, 0, 0);
    @(negedge CLK);
    RST = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("mid_rst_ce",    32'(b2.SramCE), 0);
    chk("mid_rst_ack",   32'(b2.DataMemAck), 0);
    chk("mid_rst_rdata", b2.ReadDataOriginal, 0);
    chk("mid_rst_addr",  32'(b2.SramAddr), 0);
    @(negedge CLK);
    RST = 1'b1;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      if (b2.SramCE || b2.DataMemAck) n++;
    end
    chk("post_rst_quiet", n, 0);
    acc(0, 0, 1, 32'h40, 0, 0);
    chk("post_rst_ce_cyc",  ce_c, 3);
    chk("post_rst_ack_cyc", ack_c, 4);
    chk("post_rst_data",    rdat, 32'hCAFE_F00D);
    @(negedge CLK);

    // Address above the SRAM window
    acc(0, 0, 1, 32'h0001_0000, 0, 0);
`ifdef DMEM_BRIDGE_RANGE_CHECK_EN
    chk("oor_ce_n",    ce_n, 0);
    chk("oor_ack_cyc", ack_c, 4);
    chk("oor_data",    rdat, 0);
    @(negedge CLK);
    chk("oor_rerr",    32'(b2.RangeErr), 1);
    acc(0, 0, 1, 32'h40, 0, 0);
    chk("oor_rerr_sticky", 32'(b2.RangeErr), 1);
    RST = 1'b0;
    #1;
    chk("oor_rerr_rst", 32'(b2.RangeErr), 0);
    @(negedge CLK);
    RST = 1'b1;
`else
    chk("alias_ce_cyc",  ce_c, 3);
    chk("alias_addr",    sa, 0);
    chk("alias_ack_cyc", ack_c, 4);
    chk("alias_data",    rdat, 32'h0BAD_0000);
    @(negedge CLK);
    chk("alias_rerr",    32'(b2.RangeErr), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
